// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths, forwarding-source select, register aliases.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 4;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_EX
    } fwd_sel_t;

    localparam logic [RA_W-1:0] REG_SP = 4'd14;

endpackage

// File: rtl/operand_fetch_stage_forward_mux.sv
// Purpose: pick one source operand from EX result, MEM result or register-file data.
// Latency: combinational.
// Backpressure: none; pure select logic.
module forward_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RA_W   = cpu_pkg::RA_W
) (
    input  logic [RA_W-1:0]   rs,
    input  logic              ex_fwd_en,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_fwd_en,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] data
);

    fwd_sel_t sel;

    // The youngest producer wins, so EX is checked before MEM.
    always_comb begin
        sel = FWD_RF;
        if (ex_fwd_en && (ex_rd == rs)) begin
            sel = FWD_EX;
        end else if (mem_fwd_en && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_EX:  data = ex_data;
            FWD_MEM: data = mem_data;
            default: data = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Purpose: ID/EX stage; reads the register file, forwards EX/MEM results, registers operands.
// Latency: one cycle from acceptance to out_valid; a load-use hazard inserts one bubble.
// Backpressure: holds the output register while out_ready=0; in_ready drops on stall or hazard.
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RA_W   = cpu_pkg::RA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_wr_en,
    input  logic              in_is_load,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic [RA_W-1:0]   rf_addr1,
    output logic [RA_W-1:0]   rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              mem_valid,
    input  logic              mem_wr_en,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_store_data,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_wr_en,
    output logic              out_is_load,
    output logic [CNT_W-1:0]  stall_count
);

    logic              ex_fwd_en;
    logic              mem_fwd_en;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic              hazard;
    logic              advance;

    assign rf_addr1 = in_rs1;
    assign rf_addr2 = in_rs2;

    // A load's result is not ready in EX, so it is never an EX forwarding source.
    assign ex_fwd_en  = out_valid && out_wr_en && !out_is_load;
    assign mem_fwd_en = mem_valid && mem_wr_en;

    forward_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs1 (
        .rs         (in_rs1),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (out_rd),
        .ex_data    (ex_fwd_data),
        .mem_fwd_en (mem_fwd_en),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rf_data    (rf_data1),
        .data       (fwd1)
    );

    forward_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs2 (
        .rs         (in_rs2),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (out_rd),
        .ex_data    (ex_fwd_data),
        .mem_fwd_en (mem_fwd_en),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rf_data    (rf_data2),
        .data       (fwd2)
    );

    assign hazard = in_valid && out_valid && out_is_load && out_wr_en &&
                    ((in_use_rs1 && (in_rs1 == out_rd)) ||
                     (in_use_rs2 && (in_rs2 == out_rd)));

    assign advance  = out_ready || !out_valid;
    assign in_ready = flush || (advance && !hazard);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_op_a       <= '0;
            out_op_b       <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_wr_en      <= 1'b0;
            out_is_load    <= 1'b0;
            stall_count    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance && hazard) begin
            out_valid <= 1'b0;
            if (stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end else if (advance) begin
            out_valid      <= in_valid;
            out_op_a       <= fwd1;
            out_op_b       <= in_use_imm ? in_imm : fwd2;
            out_store_data <= fwd2;
            out_rd         <= in_rd;
            out_wr_en      <= in_wr_en;
            out_is_load    <= in_is_load;
        end
    end

endmodule
